// File: rtl/multicycle_core.sv
// Multicycle 8-register core: 16-bit ISA, req/ack instruction and data ports,
// NZCV flags, conditional branches and halt. One instruction in flight at a time.
module multicycle_core #(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              retire,
    output logic              halted,
    output logic [3:0]        flags
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_ORR  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_LDR  = 3'd5;
    localparam logic [2:0] OP_STR  = 3'd6;
    localparam logic [2:0] OP_B    = 3'd7;

    localparam logic [2:0] C_AL  = 3'd0;
    localparam logic [2:0] C_EQ  = 3'd1;
    localparam logic [2:0] C_NE  = 3'd2;
    localparam logic [2:0] C_MI  = 3'd3;
    localparam logic [2:0] C_CS  = 3'd4;
    localparam logic [2:0] C_HLT = 3'd7;

    state_t state, state_n;

    logic [PC_W-1:0]          pc;
    logic [3:0]               flg;
    logic                     retire_q;
    logic signed [DATA_W-1:0] rf [8];

    logic [15:0]              ir_p0;
    logic signed [DATA_W-1:0] opa_p1, opb_p1;
    logic signed [DATA_W-1:0] res_p2;

    logic [2:0] op, rd, ra, rb;
    logic [5:0] imm6;

    logic signed [DATA_W-1:0] alu_b, alu_y;
    logic [DATA_W:0]          sum_x;
    logic [3:0]               flg_n;
    logic                     take;

    assign op   = ir_p0[15:13];
    assign rd   = ir_p0[12:10];
    assign ra   = ir_p0[9:7];
    assign rb   = ir_p0[6:4];
    assign imm6 = ir_p0[5:0];

    function automatic logic signed [DATA_W-1:0] sext_d(input logic [5:0] v);
        return DATA_W'($signed(v));
    endfunction

    function automatic logic [PC_W-1:0] sext_p(input logic [5:0] v);
        return PC_W'($signed(v));
    endfunction

    function automatic logic [3:0] nzcv(input logic [DATA_W-1:0] y, input logic c,
                                        input logic v);
        return {y[DATA_W-1], (y == '0), c, v};
    endfunction

    function automatic logic add_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] y);
        return (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] y);
        return (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // EXEC: ALU, effective address and branch condition
    always_comb begin
        alu_b = ((op == OP_ADDI) || (op == OP_LDR) || (op == OP_STR)) ? sext_d(imm6) : opb_p1;
        sum_x = '0;
        alu_y = '0;
        flg_n = flg;
        case (op)
            OP_ADD, OP_ADDI: begin
                sum_x = {1'b0, opa_p1} + {1'b0, alu_b};
                alu_y = sum_x[DATA_W-1:0];
                flg_n = nzcv(alu_y, sum_x[DATA_W], add_ovf(opa_p1, alu_b, alu_y));
            end
            OP_SUB: begin
                sum_x = {1'b0, opa_p1} - {1'b0, alu_b};
                alu_y = sum_x[DATA_W-1:0];
                flg_n = nzcv(alu_y, ~sum_x[DATA_W], sub_ovf(opa_p1, alu_b, alu_y));
            end
            OP_AND: begin
                alu_y = opa_p1 & alu_b;
                flg_n = nzcv(alu_y, flg[1], flg[0]);
            end
            OP_ORR: begin
                alu_y = opa_p1 | alu_b;
                flg_n = nzcv(alu_y, flg[1], flg[0]);
            end
            default: alu_y = opa_p1 + alu_b;
        endcase

        case (rd)
            C_AL:    take = 1'b1;
            C_EQ:    take = flg[2];
            C_NE:    take = ~flg[2];
            C_MI:    take = flg[3];
            C_CS:    take = flg[1];
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = ~reset;
                if (imem_ack) state_n = S_DECODE;
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                if (op == OP_B)
                    state_n = (rd == C_HLT) ? S_HALT : S_FETCH;
                else if ((op == OP_LDR) || (op == OP_STR))
                    state_n = S_MEM;
                else
                    state_n = S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_n = (op == OP_STR) ? S_FETCH : S_WB;
            end
            S_WB:    state_n = S_FETCH;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    // Data-port outputs are forced to zero outside MEM so reset leaves them quiet.
    assign dmem_we    = dmem_req && (op == OP_STR);
    assign dmem_addr  = dmem_req ? res_p2 : '0;
    assign dmem_wdata = dmem_req ? opb_p1 : '0;
    assign imem_addr  = pc;
    assign halted     = (state == S_HALT);
    assign retire     = retire_q;
    assign flags      = flg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Architectural state: PC, flags, register file, retire pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= PC_W'(RESET_PC);
            flg      <= '0;
            retire_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            retire_q <= (state == S_WB) ||
                        ((state == S_MEM) && dmem_ack && (op == OP_STR)) ||
                        ((state == S_EXEC) && (op == OP_B));
            if ((state == S_FETCH) && imem_ack) pc <= pc + PC_W'(1);
            if (state == S_EXEC) begin
                if (op == OP_B) begin
                    if (take) pc <= pc + sext_p(imm6);
                end else begin
                    flg <= flg_n;
                end
            end
            if (state == S_WB) rf[rd] <= res_p2;
        end
    end

    // FETCH -> DECODE -> EXEC/MEM stage registers (data only)
    always_ff @(posedge clk) begin
        if ((state == S_FETCH) && imem_ack) ir_p0 <= imem_rdata;
        if (state == S_DECODE) begin
            opa_p1 <= rf[ra];
            opb_p1 <= (op == OP_STR) ? rf[rd] : rf[rb];
        end
        if (state == S_EXEC) res_p2 <= alu_y;
        if ((state == S_MEM) && dmem_ack) res_p2 <= dmem_rdata;
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: one program run on an 8-bit and a
// 16-bit/10-bit-PC instance, with fetch/retire/store scoreboards.
module tb_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [15:0] imem_rdata = '0, dmem_rdata = '0;

    logic       a_ireq, a_dreq, a_we, a_ret, a_halt;
    logic [7:0] a_iaddr, a_daddr, a_wdata;
    logic [3:0] a_flags;
    logic        b_ireq, b_dreq, b_we, b_ret, b_halt;
    logic [9:0]  b_iaddr;
    logic [15:0] b_daddr, b_wdata;
    logic [3:0]  b_flags;

    multicycle_core #(.DATA_W(8), .PC_W(8), .RESET_PC(0)) dut8 (
        .clk(clk), .reset(rst0),
        .imem_req(a_ireq), .imem_addr(a_iaddr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(a_dreq), .dmem_we(a_we), .dmem_addr(a_daddr), .dmem_wdata(a_wdata),
        .dmem_rdata(dmem_rdata[7:0]), .dmem_ack(dmem_ack),
        .retire(a_ret), .halted(a_halt), .flags(a_flags));

    multicycle_core #(.DATA_W(16), .PC_W(10), .RESET_PC(0)) dut16 (
        .clk(clk), .reset(rst1),
        .imem_req(b_ireq), .imem_addr(b_iaddr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(b_dreq), .dmem_we(b_we), .dmem_addr(b_daddr), .dmem_wdata(b_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .retire(b_ret), .halted(b_halt), .flags(b_flags));

    bit          sel = 1'b0;
    logic        m_ireq, m_dreq, m_we, m_ret, m_halt;
    logic [15:0] m_iaddr, m_daddr, m_wdata, pmask, dmask;
    logic [3:0]  m_flags;

    always_comb begin
        if (sel) begin
            m_ireq = b_ireq; m_iaddr = 16'(b_iaddr); m_dreq = b_dreq; m_we = b_we;
            m_daddr = b_daddr; m_wdata = b_wdata; m_ret = b_ret; m_halt = b_halt;
            m_flags = b_flags; pmask = 16'h03FF; dmask = 16'hFFFF;
        end else begin
            m_ireq = a_ireq; m_iaddr = 16'(a_iaddr); m_dreq = a_dreq; m_we = a_we;
            m_daddr = 16'(a_daddr); m_wdata = 16'(a_wdata); m_ret = a_ret; m_halt = a_halt;
            m_flags = a_flags; pmask = 16'h00FF; dmask = 16'h00FF;
        end
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ins;
        logic [3:0]  f8;
        logic [3:0]  f16;
        int          lat;
        bit          mem;
        bit          st;
        logic [15:0] sa;
        logic [15:0] sd;
    } vec_t;

    localparam int NV = 27;
    vec_t        tbl [NV];
    logic [15:0] imem [0:1023];
    logic [15:0] dmem [0:65535];

    logic [15:0] fq[$];
    int          rq[$];
    int          sq[$];

    int   ncmp = 0, nbad = 0, ncyc = 0, lastret = 0, dwait = 0, dcnt = 0, nstore = 0;
    logic [15:0] d_a0, d_w0;
    logic        d_we0;
    logic        dstable = 1'b1;

    function automatic logic [15:0] ei(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input int imm);
        return {op, rd, ra, 1'b0, 6'(imm)};
    endfunction

    function automatic logic [15:0] er(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 4'b0000};
    endfunction

    function automatic vec_t rec(input logic [15:0] pc, input logic [15:0] ins,
                                 input logic [3:0] f8, input logic [3:0] f16, input int lat,
                                 input bit mem, input bit st, input logic [15:0] sa,
                                 input logic [15:0] sd);
        vec_t v;
        v.pc = pc; v.ins = ins; v.f8 = f8; v.f16 = f16; v.lat = lat;
        v.mem = mem; v.st = st; v.sa = sa; v.sd = sd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h (sel=%0d cyc=%0d)", nm, act, exp, sel, ncyc);
        end
    endtask

    task automatic fail_now(input string nm);
        ncmp++;
        nbad++;
        $display("FAIL %s: DUT event with nothing expected (sel=%0d cyc=%0d)", nm, sel, ncyc);
    endtask

    // One clock: sample at negedge, then drive memory responses for the next edge.
    task automatic cycle();
        int k;
        @(negedge clk);
        ncyc++;
        if (m_ret) begin
            if (rq.size() == 0) fail_now("retire_extra");
            else begin
                k = rq.pop_front();
                check("flags", m_flags, sel ? tbl[k].f16 : tbl[k].f8);
                if (tbl[k].lat != 0)
                    check("latency", ncyc - lastret, tbl[k].lat + (tbl[k].mem ? dwait : 0));
            end
            lastret = ncyc;
        end
        if (m_ireq) begin
            imem_ack   = 1'b1;
            imem_rdata = imem[m_iaddr[9:0]];
            if (fq.size() == 0) fail_now("fetch_extra");
            else check("fetch_pc", m_iaddr, fq.pop_front() & pmask);
        end else begin
            imem_ack = 1'b0;
        end
        if (m_dreq) begin
            if (dcnt == 0) begin
                d_a0 = m_daddr; d_w0 = m_wdata; d_we0 = m_we;
            end else if (m_daddr !== d_a0 || m_wdata !== d_w0 || m_we !== d_we0) begin
                dstable = 1'b0;
            end
            if (dcnt == dwait) begin
                dmem_ack = 1'b1;
                dcnt = 0;
                if (dwait > 0) check("dmem_stable", dstable, 1);
                dstable = 1'b1;
                if (m_we) begin
                    if (sq.size() == 0) fail_now("store_extra");
                    else begin
                        k = sq.pop_front();
                        check("st_addr", m_daddr, tbl[k].sa & dmask);
                        check("st_data", m_wdata, tbl[k].sd & dmask);
                    end
                    dmem[m_daddr] = m_wdata;
                    nstore++;
                end else begin
                    dmem_rdata = dmem[m_daddr];
                end
            end else begin
                dmem_ack = 1'b0;
                dcnt++;
            end
        end else begin
            dmem_ack = 1'b0;
            dcnt = 0;
        end
    endtask

    task automatic fill_queues();
        fq.delete(); rq.delete(); sq.delete();
        for (int i = 0; i < NV; i++) begin
            fq.push_back(tbl[i].pc);
            rq.push_back(i);
            if (tbl[i].st) sq.push_back(i);
        end
    endtask

    task automatic run_program(input bit s, input int w);
        int quiet;
        sel = s;
        dwait = w;
        fill_queues();
        cycle();
        if (s) rst1 = 1'b0;
        else   rst0 = 1'b0;
        lastret = ncyc;
        for (int c = 0; c < 800 && !m_halt; c++) cycle();
        check("halted", m_halt, 1);
        check("retire_left", rq.size(), 0);
        check("fetch_left", fq.size(), 0);
        check("store_left", sq.size(), 0);
        check("final_flags", m_flags, s ? 4'b1000 : 4'b1001);
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (m_ireq || m_dreq || m_ret) quiet++;
        end
        check("halt_quiet", quiet, 0);
        check("halt_held", m_halt, 1);
    endtask

    initial begin
        int nst0;
        tbl[0]  = rec(16'd0,    ei(3'd4, 3'd1, 3'd0, 5),   4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        tbl[1]  = rec(16'd1,    ei(3'd4, 3'd2, 3'd0, -3),  4'b1000, 4'b1000, 4, 0, 0, 0, 0);
        tbl[2]  = rec(16'd2,    er(3'd0, 3'd3, 3'd1, 3'd2), 4'b0010, 4'b0010, 4, 0, 0, 0, 0);
        tbl[3]  = rec(16'd3,    er(3'd1, 3'd4, 3'd1, 3'd1), 4'b0110, 4'b0110, 4, 0, 0, 0, 0);
        tbl[4]  = rec(16'd4,    ei(3'd7, 3'd1, 3'd0, 2),   4'b0110, 4'b0110, 3, 0, 0, 0, 0);
        tbl[5]  = rec(16'd7,    ei(3'd7, 3'd2, 3'd0, 5),   4'b0110, 4'b0110, 3, 0, 0, 0, 0);
        tbl[6]  = rec(16'd8,    ei(3'd6, 3'd3, 3'd0, 10),  4'b0110, 4'b0110, 4, 1, 1, 16'd10, 16'd2);
        tbl[7]  = rec(16'd9,    ei(3'd5, 3'd5, 3'd0, 10),  4'b0110, 4'b0110, 5, 1, 0, 0, 0);
        tbl[8]  = rec(16'd10,   ei(3'd6, 3'd5, 3'd0, 11),  4'b0110, 4'b0110, 4, 1, 1, 16'd11, 16'd2);
        tbl[9]  = rec(16'd11,   ei(3'd4, 3'd6, 3'd0, 31),  4'b0000, 4'b0000, 4, 0, 0, 0, 0);
        tbl[10] = rec(16'd12,   ei(3'd4, 3'd6, 3'd6, 31),  4'b0000, 4'b0000, 4, 0, 0, 0, 0);
        tbl[11] = rec(16'd13,   ei(3'd4, 3'd6, 3'd6, 31),  4'b0000, 4'b0000, 4, 0, 0, 0, 0);
        tbl[12] = rec(16'd14,   ei(3'd4, 3'd6, 3'd6, 31),  4'b0000, 4'b0000, 4, 0, 0, 0, 0);
        tbl[13] = rec(16'd15,   ei(3'd4, 3'd6, 3'd6, 3),   4'b0000, 4'b0000, 4, 0, 0, 0, 0);
        tbl[14] = rec(16'd16,   ei(3'd4, 3'd7, 3'd6, 1),   4'b1001, 4'b0000, 4, 0, 0, 0, 0);
        tbl[15] = rec(16'd17,   ei(3'd6, 3'd7, 3'd0, 12),  4'b1001, 4'b0000, 4, 1, 1, 16'd12, 16'h0080);
        tbl[16] = rec(16'd18,   ei(3'd6, 3'd2, 3'd0, 13),  4'b1001, 4'b0000, 4, 1, 1, 16'd13, 16'hFFFD);
        tbl[17] = rec(16'd19,   ei(3'd6, 3'd3, 3'd1, -6),  4'b1001, 4'b0000, 4, 1, 1, 16'hFFFF, 16'd2);
        tbl[18] = rec(16'd20,   ei(3'd7, 3'd0, 3'd0, -22), 4'b1001, 4'b0000, 3, 0, 0, 0, 0);
        tbl[19] = rec(16'hFFFF, ei(3'd7, 3'd0, 3'd0, 24),  4'b1001, 4'b0000, 3, 0, 0, 0, 0);
        tbl[20] = rec(16'd24,   er(3'd2, 3'd4, 3'd2, 3'd1), 4'b0001, 4'b0000, 4, 0, 0, 0, 0);
        tbl[21] = rec(16'd25,   ei(3'd7, 3'd3, 3'd0, 3),   4'b0001, 4'b0000, 3, 0, 0, 0, 0);
        tbl[22] = rec(16'd26,   er(3'd3, 3'd4, 3'd2, 3'd0), 4'b1001, 4'b1000, 4, 0, 0, 0, 0);
        tbl[23] = rec(16'd27,   ei(3'd7, 3'd3, 3'd0, 1),   4'b1001, 4'b1000, 3, 0, 0, 0, 0);
        tbl[24] = rec(16'd29,   ei(3'd7, 3'd4, 3'd0, 3),   4'b1001, 4'b1000, 3, 0, 0, 0, 0);
        tbl[25] = rec(16'd30,   ei(3'd7, 3'd5, 3'd0, 3),   4'b1001, 4'b1000, 3, 0, 0, 0, 0);
        tbl[26] = rec(16'd31,   ei(3'd7, 3'd7, 3'd0, 0),   4'b1001, 4'b1000, 3, 0, 0, 0, 0);

        for (int i = 0; i < 1024; i++) imem[i] = 16'hFFFF;
        for (int i = 0; i < 65536; i++) dmem[i] = 16'h0000;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].pc == 16'hFFFF) begin
                imem[255]  = tbl[i].ins;
                imem[1023] = tbl[i].ins;
            end else begin
                imem[tbl[i].pc[9:0]] = tbl[i].ins;
            end
        end

        #1;
        check("rst_ireq",  m_ireq, 0);
        check("rst_iaddr", m_iaddr, 0);
        check("rst_dreq",  {m_dreq, m_we, m_daddr, m_wdata}, 0);
        check("rst_ret_halt", {m_ret, m_halt}, 0);
        check("rst_flags", m_flags, 0);

        run_program(1'b0, 3);

        // Reset asserted mid-store with the data port stalled
        rst0 = 1'b1;
        cycle();
        dmem[10] = 16'hAAAA;
        nst0 = nstore;
        dwait = 20;
        fill_queues();
        rst0 = 1'b0;
        for (int c = 0; c < 300 && !(m_dreq && dcnt >= 5); c++) cycle();
        check("mem_reached", m_dreq, 1);
        #2 rst0 = 1'b1;
        #1;
        check("async_dreq_drop", m_dreq, 0);
        check("async_ireq_low", m_ireq, 0);
        check("async_pc", m_iaddr, 0);
        check("async_flags", m_flags, 0);
        cycle();
        cycle();
        check("no_store_mem", dmem[10], 16'hAAAA);
        check("no_store_cnt", nstore, nst0);

        run_program(1'b0, 0);

        rst0 = 1'b1;
        run_program(1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
